// File: rtl/fsync_pkg.sv
// Shared definitions for the flag synchronizer family: ratio-derived widths,
// the expander state encoding and the statistics counter width.
package fsync_pkg;

   localparam int STAT_W = 32'sd32;

   typedef enum logic [0:0] {
      ST_RUN = 1'b0,
      ST_ERR = 1'b1
   } state_e;

   // Largest legal per-cycle flag count for a given ratio: 2*|ratio|.
   function automatic int fsync_sn(input int ratio);
      if (ratio < 32'sd0) begin
         return -(32'sd2 * ratio);
      end else begin
         return 32'sd2 * ratio;
      end
   endfunction

   // Bits needed to carry 0..SN inclusive; never narrower than one bit.
   function automatic int fsync_iw(input int ratio);
      int w;
      w = $clog2(fsync_sn(ratio) + 32'sd1);
      if (w < 32'sd1) begin
         return 32'sd1;
      end else begin
         return w;
      end
   endfunction

endpackage

// File: rtl/fsync_expand_if.sv
// Flag-count in / single-event out bundle for fsync_expand.
// Carries the statistics outputs when FSYNC_EXPAND_STATS_EN is defined.
interface fsync_expand_if
   import fsync_pkg::*;
#(
   parameter int IW = 3,
   parameter int CW = 8
) ();

   logic [IW-1:0]     icnt;
   logic              clr;
   logic              ovld;
   logic              ordy;
   logic [CW-1:0]     pend;
   logic              afull;
   logic              err;
`ifdef FSYNC_EXPAND_STATS_EN
   logic [STAT_W-1:0] stat_in;
   logic [STAT_W-1:0] stat_out;
   logic [CW-1:0]     stat_peak;

   modport master (
      output icnt, clr, ordy,
      input  ovld, pend, afull, err, stat_in, stat_out, stat_peak
   );
   modport slave (
      input  icnt, clr, ordy,
      output ovld, pend, afull, err, stat_in, stat_out, stat_peak
   );
`else
   modport master (
      output icnt, clr, ordy,
      input  ovld, pend, afull, err
   );
   modport slave (
      input  icnt, clr, ordy,
      output ovld, pend, afull, err
   );
`endif

endinterface

// File: rtl/fsync_expand_stats.sv
// Traffic statistics for fsync_expand: accepted flags, takes and peak pending
// count. Instantiated only when FSYNC_EXPAND_STATS_EN is defined.
module fsync_expand_stats
   import fsync_pkg::*;
#(
   parameter int IW = 3,
   parameter int CW = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   input  logic [IW-1:0]     acc,
   input  logic              take,
   input  logic [CW-1:0]     pend_nxt,
   output logic [STAT_W-1:0] stat_in,
   output logic [STAT_W-1:0] stat_out,
   output logic [CW-1:0]     stat_peak
);

   logic [STAT_W-1:0] in_r;
   logic [STAT_W-1:0] out_r;
   logic [CW-1:0]     peak_r;

   // Counters wrap naturally; peak follows the value pend takes on this edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_r   <= {STAT_W{1'b0}};
         out_r  <= {STAT_W{1'b0}};
         peak_r <= {CW{1'b0}};
      end else if (clr) begin
         in_r   <= {STAT_W{1'b0}};
         out_r  <= {STAT_W{1'b0}};
         peak_r <= {CW{1'b0}};
      end else begin
         in_r  <= in_r + STAT_W'(acc);
         out_r <= out_r + STAT_W'(take);
         if (pend_nxt > peak_r) begin
            peak_r <= pend_nxt;
         end
      end
   end

   assign stat_in   = in_r;
   assign stat_out  = out_r;
   assign stat_peak = peak_r;

endmodule

// File: rtl/fsync_expand.sv
// Re-serializes per-cycle flag counts into single events under valid/ready.
// Optional statistics outputs are enabled by defining FSYNC_EXPAND_STATS_EN.
module fsync_expand
   import fsync_pkg::*;
#(
   parameter int RATIO = 2,
   parameter int CW    = 8,
   parameter int AFULL = (32'sd1 <<< CW) - 32'sd1 - fsync_sn(RATIO)
) (
   input  logic            clk,
   input  logic            rst_n,
   fsync_expand_if.slave   bus
);

   localparam int              SN      = fsync_sn(RATIO);
   localparam int              IW      = fsync_iw(RATIO);
   localparam logic [CW:0]     PMAX    = {1'b0, {CW{1'b1}}};
   localparam logic [IW-1:0]   SN_W    = IW'(SN);
   localparam logic [CW-1:0]   AFULL_W = CW'(AFULL);

   logic [CW-1:0] pend_r;
   logic [CW-1:0] pend_d;
   logic          afull_r;
   logic          afull_d;
   logic          err_r;
   logic          err_d;
   state_e        state_r;
   state_e        state_d;
   logic [IW-1:0] icnt_eff_s;
   logic          ill_s;
   logic          take_s;
   logic          ovf_s;
   logic [CW:0]   nxt_s;

   // ovld is pend != 0, so it can never depend on ordy combinationally.
   assign take_s = (pend_r != {CW{1'b0}}) && bus.ordy;

   // Pending-count arithmetic at CW+1 bits so saturation can be detected.
   always_comb begin
      ill_s = (bus.icnt > SN_W);
      if (ill_s) begin
         icnt_eff_s = SN_W;
      end else begin
         icnt_eff_s = bus.icnt;
      end
      nxt_s = {1'b0, pend_r} + (CW+1)'(icnt_eff_s) - (CW+1)'(take_s);
      ovf_s = (nxt_s > PMAX);
      if (ovf_s) begin
         pend_d = PMAX[CW-1:0];
      end else begin
         pend_d = nxt_s[CW-1:0];
      end
      afull_d = (pend_d >= AFULL_W);
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_RUN;
      end else begin
         state_r <= state_d;
      end
   end

   // Next state: a fresh fault in the clearing cycle keeps the machine in ERR.
   always_comb begin
      state_d = state_r;
      case (state_r)
         ST_RUN: begin
            if (ovf_s || ill_s) begin
               state_d = ST_ERR;
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_ERR: begin
            if (bus.clr && !(ovf_s || ill_s)) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_ERR;
            end
         end
         default: state_d = ST_RUN;
      endcase
   end

   // Output decode: err mirrors the state being entered.
   always_comb begin
      err_d = 1'b0;
      case (state_d)
         ST_RUN:  err_d = 1'b0;
         ST_ERR:  err_d = 1'b1;
         default: err_d = 1'b1;
      endcase
   end

   // Registered pending count and flags.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_r  <= {CW{1'b0}};
         afull_r <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         pend_r  <= pend_d;
         afull_r <= afull_d;
         err_r   <= err_d;
      end
   end

   assign bus.ovld  = (pend_r != {CW{1'b0}});
   assign bus.pend  = pend_r;
   assign bus.afull = afull_r;
   assign bus.err   = err_r;

`ifdef FSYNC_EXPAND_STATS_EN
   logic [IW-1:0] acc_s;

   // Flags actually stored this cycle; on saturation only the headroom counts.
   always_comb begin
      if (ovf_s) begin
         acc_s = IW'(PMAX - {1'b0, pend_r} + (CW+1)'(take_s));
      end else begin
         acc_s = icnt_eff_s;
      end
   end

   fsync_expand_stats #(
      .IW (IW),
      .CW (CW)
   ) u_stats (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (bus.clr),
      .acc       (acc_s),
      .take      (take_s),
      .pend_nxt  (pend_d),
      .stat_in   (bus.stat_in),
      .stat_out  (bus.stat_out),
      .stat_peak (bus.stat_peak)
   );
`endif

endmodule

// File: tb/tb_fsync_expand.sv
// Scoreboard bench for fsync_expand (RATIO=2, CW=4, so PMAX=15 and AFULL=11).
// Directed vectors carry hand-computed post-edge expectations.
module tb_fsync_expand;

   localparam int CW = 4;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   fsync_expand_if #(.IW(3), .CW(CW)) bus ();

   fsync_expand #(.RATIO(2), .CW(CW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct packed {
      logic [2:0] icnt;
      logic       ordy;
      logic       clr;
      logic [3:0] pend;
      logic       afull;
      logic       err;
   } vec_t;

   vec_t stim_q[$];
   vec_t exp_q[$];
   vec_t mon_e;
   int   checks   = 0;
   int   failures = 0;
   int   xfers    = 0;
   int   vidx     = 0;
   int   x0;

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic add(input int icnt, input int ordy, input int clr,
                      input int pend, input int afull, input int err);
      vec_t v;
      v.icnt  = 3'(icnt);
      v.ordy  = 1'(ordy);
      v.clr   = 1'(clr);
      v.pend  = 4'(pend);
      v.afull = 1'(afull);
      v.err   = 1'(err);
      stim_q.push_back(v);
   endtask

   task automatic run();
      vec_t v;
      while (stim_q.size() > 0) begin
         v = stim_q.pop_front();
         @(posedge clk);
         #2;
         bus.icnt = v.icnt;
         bus.ordy = v.ordy;
         bus.clr  = v.clr;
         exp_q.push_back(v);
      end
      @(posedge clk);
      #2;
      bus.icnt = 3'd0;
      bus.ordy = 1'b0;
      bus.clr  = 1'b0;
   endtask

   // Monitor: compare post-edge outputs against the queued expectation.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk($sformatf("pend[v%0d]", vidx), int'(bus.pend), int'(mon_e.pend));
            chk($sformatf("ovld[v%0d]", vidx), int'(bus.ovld), int'(mon_e.pend != 4'd0));
            chk($sformatf("afull[v%0d]", vidx), int'(bus.afull), int'(mon_e.afull));
            chk($sformatf("err[v%0d]", vidx), int'(bus.err), int'(mon_e.err));
            vidx++;
         end
      end
   end

   // Transfer counter: inputs are stable around the falling edge.
   always @(negedge clk) begin
      if (rst_n && bus.ovld && bus.ordy) begin
         xfers++;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n    = 1'b0;
      bus.icnt = 3'd0;
      bus.ordy = 1'b0;
      bus.clr  = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      #1;
      chk("reset_pend", int'(bus.pend), 0);
      chk("reset_ovld", int'(bus.ovld), 0);
      chk("reset_afull", int'(bus.afull), 0);
      chk("reset_err", int'(bus.err), 0);

      // Burst drain: one cycle of 4 flags, consumer always ready.
      add(4, 1, 0, 4, 0, 0);
      for (int i = 3; i >= 0; i--) add(0, 1, 0, i, 0, 0);
      add(0, 1, 0, 0, 0, 0);
      x0 = xfers;
      run();
      chk("burst_xfers", xfers - x0, 4);

      // Backpressure then release.
      for (int i = 1; i <= 10; i++) add(1, 0, 0, i, 0, 0);
      for (int i = 9; i >= 0; i--) add(0, 1, 0, i, 0, 0);
      add(0, 1, 0, 0, 0, 0);
      x0 = xfers;
      run();
      chk("backpressure_xfers", xfers - x0, 10);

      // Simultaneous arrival/take, saturation, set-wins-over-clear, legal PMAX.
      add(4, 0, 0, 4, 0, 0);
      add(3, 0, 0, 7, 0, 0);
      add(3, 1, 0, 9, 0, 0);
      add(4, 0, 0, 13, 1, 0);
      add(1, 0, 0, 14, 1, 0);
      add(4, 0, 0, 15, 1, 1);
      add(2, 0, 1, 15, 1, 1);
      add(0, 0, 1, 15, 1, 0);
      add(1, 1, 0, 15, 1, 0);
      add(0, 1, 1, 14, 1, 0);
      for (int i = 13; i >= 0; i--) add(0, 1, 0, i, (i >= 11) ? 1 : 0, 0);
      run();

      // Illegal count saturates to SN and raises err.
      add(7, 0, 0, 4, 0, 1);
      add(0, 1, 1, 3, 0, 0);
      for (int i = 2; i >= 0; i--) add(0, 1, 0, i, 0, 0);
      run();

      // Asynchronous reset with events pending and err set.
      add(7, 0, 0, 4, 0, 1);
      add(1, 0, 0, 5, 0, 1);
      run();
      #3;
      rst_n = 1'b0;
      #1;
      chk("async_rst_pend", int'(bus.pend), 0);
      chk("async_rst_ovld", int'(bus.ovld), 0);
      chk("async_rst_err", int'(bus.err), 0);
      chk("async_rst_afull", int'(bus.afull), 0);
      @(negedge clk);
      rst_n = 1'b1;
      add(2, 0, 0, 2, 0, 0);
      add(0, 1, 0, 1, 0, 0);
      add(0, 1, 0, 0, 0, 0);
      run();

      // 20 flags in, 12 takes, peak pend 11.
      add(0, 0, 1, 0, 0, 0);
      for (int i = 0; i < 10; i++) add(2, 1, 0, 2 + i, (2 + i >= 11) ? 1 : 0, 0);
      for (int i = 10; i >= 8; i--) add(0, 1, 0, i, 0, 0);
      x0 = xfers;
      run();
      chk("stats_seq_xfers", xfers - x0, 12);
`ifdef FSYNC_EXPAND_STATS_EN
      chk("stat_in", int'(bus.stat_in), 20);
      chk("stat_out", int'(bus.stat_out), 12);
      chk("stat_peak", int'(bus.stat_peak), 11);
`endif
      for (int i = 7; i >= 0; i--) add(0, 1, 0, i, 0, 0);
      run();

      @(posedge clk);
      #2;
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
